wb_ram_slave_b3: RTL and testbench

- Wishbone B3 slave (responder) with internal single-port word RAM; answers the tile bus initiators (core, network adapter DMA) through one wb_bus_b3 slave port.
- Supports classic single cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16); flags out-of-range accesses with err.
- Intended for tile-local scratch/boot memory (the WBRAM slave slot).

---
 rtl/wb_b3_pkg.sv | 23 ++
 rtl/wb_b3_burst_adr.sv | 23 ++
 rtl/wb_ram_slave_b3.sv | 156 +++++++++++++++
 tb/tb_wb_ram_slave_b3.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 registered-feedback constants and the wrap-burst word mask.
package wb_b3_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Word-address bits that roll over inside a wrap burst; zero for linear.
   function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
      case (bte)
         BTE_WRAP4:  return 4'h3;
         BTE_WRAP8:  return 4'h7;
         BTE_WRAP16: return 4'hF;
         default:    return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/wb_b3_burst_adr.sv
// Next word address of a B3 incrementing burst, with a flag when a linear
// burst runs past the top of the AW-bit word space.
module wb_b3_burst_adr
   import wb_b3_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic [AW-1:0] adr,
   input  logic [1:0]    bte,
   output logic [AW-1:0] nxt,
   output logic          ovf
);

   logic [AW:0]   inc;
   logic [AW-1:0] mask;

   assign inc  = {1'b0, adr} + (AW+1)'(1);
   assign mask = AW'(wrap_mask(bte));
   assign nxt  = (bte == BTE_LINEAR) ? inc[AW-1:0]
                                     : ((adr & ~mask) | (inc[AW-1:0] & mask));
   assign ovf  = (bte == BTE_LINEAR) && inc[AW];

endmodule

// File: rtl/wb_ram_slave_b3.sv
// Wishbone B3 slave fronting a single-port word RAM: classic cycles with one
// wait state, zero-wait incrementing bursts, err on out-of-range accesses.
module wb_ram_slave_b3
   import wb_b3_pkg::*;
#(
   parameter int    DATA_WIDTH     = 32,
   parameter int    ADDR_WIDTH     = 32,
   parameter int    MEM_SIZE_BYTES = 4096,
   parameter string MEM_FILE       = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
   input  logic [DATA_WIDTH-1:0] wbs_dat_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic                  wbs_we_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic [2:0]            wbs_cti_i,
   input  logic [1:0]            wbs_bte_i,
   output logic [DATA_WIDTH-1:0] wbs_dat_o,
   output logic                  wbs_ack_o,
   output logic                  wbs_err_o,
   output logic                  wbs_rty_o
);

   localparam int MEM_WORDS = MEM_SIZE_BYTES / 4;
   localparam int WA        = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST} state_t;

   state_t                state;
   logic                  ack_q, err_q;
   logic [WA-1:0]         burst_adr, nxt_adr, adr_idx, wr_idx, rd_idx;
   logic                  nxt_ovf, out_of_range, wr_en, rd_en;
   logic [DATA_WIDTH-1:0] dat_q, rd_word;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic                  unused_adr_bits;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [3:0]            sel);
      logic [DATA_WIDTH-1:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return res;
   endfunction

   assign adr_idx         = wbs_adr_i[WA+1:2];
   assign out_of_range    = |wbs_adr_i[ADDR_WIDTH-1:WA+2];
   assign unused_adr_bits = ^wbs_adr_i[1:0];

   wb_b3_burst_adr #(.AW(WA)) u_burst_adr (
      .adr (burst_adr),
      .bte (wbs_bte_i),
      .nxt (nxt_adr),
      .ovf (nxt_ovf)
   );

   // RAM port steering: bursts prefetch the following word on every beat.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = burst_adr;
      rd_en  = 1'b0;
      rd_idx = adr_idx;
      case (state)
         S_IDLE: begin
            rd_en = wbs_cyc_i && wbs_stb_i && !err_q && !out_of_range;
         end
         S_CLASSIC: begin
            wr_idx = adr_idx;
            wr_en  = wbs_cyc_i && wbs_stb_i && ack_q && wbs_we_i;
         end
         S_BURST: begin
            wr_en  = wbs_cyc_i && wbs_stb_i && ack_q && wbs_we_i;
            rd_en  = wbs_cyc_i && wbs_stb_i && ack_q;
            rd_idx = nxt_adr;
         end
         default: ;
      endcase
   end

   assign rd_word = (wr_en && (wr_idx == rd_idx)) ? merge_lanes(mem[rd_idx], wbs_dat_i, wbs_sel_i)
                                                  : mem[rd_idx];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr_en && wbs_sel_i[i])
            mem[wr_idx][8*i +: 8] <= wbs_dat_i[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst)        dat_q <= '0;
      else if (rd_en) dat_q <= rd_word;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         burst_adr <= '0;
      end else if (!wbs_cyc_i) begin
         state <= S_IDLE;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // An err beat completes here; do not re-decode the same request.
               if (err_q) begin
                  err_q <= 1'b0;
               end else if (wbs_stb_i) begin
                  if (out_of_range) begin
                     err_q <= 1'b1;
                  end else if (wbs_cti_i == CTI_INCR) begin
                     burst_adr <= adr_idx;
                     ack_q     <= 1'b1;
                     state     <= S_BURST;
                  end else begin
                     ack_q <= 1'b1;
                     state <= S_CLASSIC;
                  end
               end
            end
            S_CLASSIC: begin
               if (wbs_stb_i) begin
                  ack_q <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_BURST: begin
               if (wbs_stb_i) begin
                  if (wbs_cti_i != CTI_INCR) begin
                     ack_q <= 1'b0;
                     state <= S_IDLE;
                  end else if (nxt_ovf) begin
                     ack_q <= 1'b0;
                     err_q <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     burst_adr <= nxt_adr;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign wbs_dat_o = dat_q;
   assign wbs_ack_o = ack_q && wbs_cyc_i && wbs_stb_i;
   assign wbs_err_o = err_q && wbs_cyc_i && wbs_stb_i;
   assign wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave_b3.sv
// Directed bench for wb_ram_slave_b3: classic, byte-masked, wrap and linear
// bursts with stall, range errors, cyc abort and mid-burst reset.
module tb_wb_ram_slave_b3;

   logic        clk;
   logic        rst;
   logic [31:0] adr;
   logic [31:0] dat_i;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_o;
   logic        ack;
   logic        err;
   logic        rty;

   int n_cmp = 0;
   int n_bad = 0;

   wb_ram_slave_b3 #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .MEM_SIZE_BYTES (4096),
      .MEM_FILE       ("")
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wbs_adr_i (adr),
      .wbs_dat_i (dat_i),
      .wbs_sel_i (sel),
      .wbs_we_i  (we),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_cti_i (cti),
      .wbs_bte_i (bte),
      .wbs_dat_o (dat_o),
      .wbs_ack_o (ack),
      .wbs_err_o (err),
      .wbs_rty_o (rty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One more cycle with the request still asserted: ack/err must already be low.
   task automatic hold_end(input string tag);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_ack_lo"}, 32'(ack), 32'd0);
      chk({tag, "_err_lo"}, 32'(err), 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'hF;
   endtask

   task automatic classic(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, output logic [31:0] rd);
      @(posedge clk); #1;
      adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("cl_wait", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cl_ack", 32'(ack), 32'd1);
      rd = dat_o;
      hold_end("cl");
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      classic(a, d, s, 1'b1, dummy);
   endtask

   task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      classic(a, 32'h0, 4'hF, 1'b0, rd);
      chk(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] wadr [4];
      logic [31:0] wexp [4];
      wadr = '{32'h0C, 32'h00, 32'h04, 32'h08};
      wexp = '{32'd3, 32'd0, 32'd1, 32'd2};

      rst = 1'b1; adr = '0; dat_i = '0; sel = 4'hF; we = 1'b0;
      cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_rty", 32'(rty), 32'd0);
      rst = 1'b0;

      wr(32'h10, 32'hDEADBEEF, 4'hF);
      rdchk("cl_rd", 32'h10, 32'hDEADBEEF);
      wr(32'h10, 32'h000000AA, 4'b0001);
      rdchk("byte_rd", 32'h10, 32'hDEADBEAA);
      wr(32'h10, 32'h12345678, 4'b0000);
      rdchk("sel0_rd", 32'h10, 32'hDEADBEAA);

      for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'(i), 4'hF);

      // wrap4 read burst from 0x0C
      @(posedge clk); #1;
      adr = 32'h0C; we = 1'b0; cti = 3'b010; bte = 2'b01; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("wr4_wait", 32'(ack), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         adr = wadr[i];
         cti = (i == 3) ? 3'b111 : 3'b010;
         @(negedge clk);
         chk("wr4_ack", 32'(ack), 32'd1);
         chk("wr4_dat", dat_o, wexp[i]);
      end
      hold_end("wr4");

      // linear 8-beat write burst with a 2-cycle stall after the third beat
      @(posedge clk); #1;
      adr = 32'h100; dat_i = 32'hC0DE0000; sel = 4'hF; we = 1'b1;
      cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("lin_wait", 32'(ack), 32'd0);
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin
            for (int s = 0; s < 2; s++) begin
               @(posedge clk); #1;
               stb = 1'b0;
               @(negedge clk);
               chk("lin_stall", 32'(ack), 32'd0);
            end
         end
         @(posedge clk); #1;
         stb = 1'b1; adr = 32'h100 + 32'(4 * k); dat_i = 32'hC0DE0000 | 32'(k);
         cti = (k == 7) ? 3'b111 : 3'b010;
         @(negedge clk);
         chk("lin_ack", 32'(ack), 32'd1);
      end
      hold_end("lin");
      for (int k = 0; k < 8; k++)
         rdchk("lin_rd", 32'h100 + 32'(4 * k), 32'hC0DE0000 | 32'(k));

      // out-of-range classic read
      @(posedge clk); #1;
      adr = 32'h2000; we = 1'b0; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("oor_err0", 32'(err), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_noack", 32'(ack), 32'd0);
      hold_end("oor");

      // linear burst running off the top of the RAM
      @(posedge clk); #1;
      adr = 32'hFFC; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("ovf_wait", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ovf_b1_ack", 32'(ack), 32'd1);
      chk("ovf_b1_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      adr = 32'h1000;
      @(negedge clk);
      chk("ovf_b2_ack", 32'(ack), 32'd0);
      chk("ovf_b2_err", 32'(err), 32'd1);
      hold_end("ovf");

      // cyc dropped on beat 2 of a write burst
      wr(32'h204, 32'h55AA55AA, 4'hF);
      @(posedge clk); #1;
      adr = 32'h200; dat_i = 32'h11111111; sel = 4'hF; we = 1'b1;
      cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("abt_wait", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abt_b1_ack", 32'(ack), 32'd1);
      @(posedge clk); #1;
      cyc = 1'b0; adr = 32'h204; dat_i = 32'h22222222;
      @(negedge clk);
      chk("abt_b2_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      stb = 1'b0; we = 1'b0; cti = 3'b000;
      rdchk("abt_b2_rd", 32'h204, 32'h55AA55AA);
      rdchk("abt_b1_rd", 32'h200, 32'h11111111);

      // reset asserted mid-burst
      @(posedge clk); #1;
      adr = 32'h0; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      chk("rb_wait", 32'(ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rb_b1_ack", 32'(ack), 32'd1);
      chk("rb_b1_dat", dat_o, 32'd0);
      @(posedge clk); #1;
      adr = 32'h4;
      @(negedge clk);
      chk("rb_b2_ack", 32'(ack), 32'd1);
      chk("rb_b2_dat", dat_o, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rb_ack", 32'(ack), 32'd0);
      chk("rb_err", 32'(err), 32'd0);
      chk("rb_dat", dat_o, 32'd0);
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      rdchk("post_rst_rd", 32'h10, 32'hDEADBEAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
